// File: rtl/branch_predictor.sv
// Branch target buffer with saturating-counter direction prediction for the 5-stage pipe.
// Define BRANCH_PREDICT_STATS_EN to add the stat_updates / stat_mispredicts counters.
module branch_predictor #(
    parameter int ENTRIES      = 16,
    parameter int COUNTER_BITS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if__pc,
    input  logic        if__stall,
    input  logic        mb__update,
    input  logic [31:0] mb__pc,
    input  logic        mb__taken,
    input  logic [31:0] mb__target,
    input  logic        mb__mispredict,
    output logic        if_id__predict_taken,
    output logic [31:0] if_id__predict_target
`ifdef BRANCH_PREDICT_STATS_EN
    ,
    output logic [31:0] stat_updates,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX;
    localparam logic [COUNTER_BITS-1:0] CTR_MAX  = '1;
    localparam logic [COUNTER_BITS-1:0] CTR_WEAK = COUNTER_BITS'(1) << (COUNTER_BITS - 1);

    function automatic logic [COUNTER_BITS-1:0] sat_inc(input logic [COUNTER_BITS-1:0] c);
        return (c == CTR_MAX) ? c : c + 1'b1;
    endfunction

    function automatic logic [COUNTER_BITS-1:0] sat_dec(input logic [COUNTER_BITS-1:0] c);
        return (c == '0) ? c : c - 1'b1;
    endfunction

    logic [ENTRIES-1:0]      valid_q, valid_d;
    logic [TAG_W-1:0]        tag_q    [ENTRIES];
    logic [TAG_W-1:0]        tag_d    [ENTRIES];
    logic [31:0]             target_q [ENTRIES];
    logic [31:0]             target_d [ENTRIES];
    logic [COUNTER_BITS-1:0] ctr_q    [ENTRIES];
    logic [COUNTER_BITS-1:0] ctr_d    [ENTRIES];

    logic                    pred_taken_q, pred_taken_d;
    logic [31:0]             pred_target_q, pred_target_d;

    logic [IDX-1:0]          lk_idx;
    logic [TAG_W-1:0]        lk_tag;
    logic                    lk_hit;
    logic                    lk_taken;
    logic [31:0]             lk_target;

    logic [IDX-1:0]          up_idx;
    logic [TAG_W-1:0]        up_tag;
    logic                    up_hit;

    // Lookup reads the table as it stands before this edge's update (read-before-write).
    always_comb begin
        lk_idx    = if__pc[IDX+1:2];
        lk_tag    = if__pc[31:IDX+2];
        lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        lk_taken  = lk_hit && ctr_q[lk_idx][COUNTER_BITS-1];
        lk_target = lk_taken ? target_q[lk_idx] : if__pc + 32'd4;
    end

    always_comb begin
        pred_taken_d  = pred_taken_q;
        pred_target_d = pred_target_q;
        if (!if__stall) begin
            pred_taken_d  = lk_taken;
            pred_target_d = lk_target;
        end
    end

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        up_idx   = mb__pc[IDX+1:2];
        up_tag   = mb__pc[31:IDX+2];
        up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        if (mb__update) begin
            if (up_hit) begin
                if (mb__taken) begin
                    ctr_d[up_idx]    = sat_inc(ctr_q[up_idx]);
                    target_d[up_idx] = mb__target;
                end else begin
                    ctr_d[up_idx]    = sat_dec(ctr_q[up_idx]);
                end
            end else if (mb__taken) begin
                // Taken miss: allocate weakly taken, evicting any aliasing occupant.
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = up_tag;
                target_d[up_idx] = mb__target;
                ctr_d[up_idx]    = CTR_WEAK;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q       <= '0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= 32'd0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= '0;
            end
        end else begin
            valid_q       <= valid_d;
            pred_taken_q  <= pred_taken_d;
            pred_target_q <= pred_target_d;
            ctr_q         <= ctr_d;
        end
    end

    // Tag and target are only meaningful behind a valid bit, so they carry no reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tag_q    <= tag_d;
            target_q <= target_d;
        end
    end

    assign if_id__predict_taken  = pred_taken_q;
    assign if_id__predict_target = pred_target_q;

`ifdef BRANCH_PREDICT_STATS_EN
    logic [31:0] stat_updates_q, stat_updates_d;
    logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

    always_comb begin
        stat_updates_d     = stat_updates_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (mb__update) begin
            stat_updates_d = stat_updates_q + 32'd1;
            if (mb__mispredict) begin
                stat_mispredicts_d = stat_mispredicts_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_updates_q     <= 32'd0;
            stat_mispredicts_q <= 32'd0;
        end else begin
            stat_updates_q     <= stat_updates_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_updates     = stat_updates_q;
    assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: default instance (16 entries, 2-bit counters) and a
// small instance (2 entries, 1-bit counters) driven in lockstep against a reference model.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if__pc;
    logic        if__stall;
    logic        mb__update;
    logic [31:0] mb__pc;
    logic        mb__taken;
    logic [31:0] mb__target;
    logic        mb__mispredict;

    logic        a_taken, b_taken;
    logic [31:0] a_target, b_target;
`ifdef BRANCH_PREDICT_STATS_EN
    logic [31:0] a_upd, a_mis, b_upd, b_mis;
`endif

    branch_predictor #(.ENTRIES(16), .COUNTER_BITS(2)) dut_a (
        .clk(clk), .rst(rst), .if__pc(if__pc), .if__stall(if__stall),
        .mb__update(mb__update), .mb__pc(mb__pc), .mb__taken(mb__taken),
        .mb__target(mb__target), .mb__mispredict(mb__mispredict),
        .if_id__predict_taken(a_taken), .if_id__predict_target(a_target)
`ifdef BRANCH_PREDICT_STATS_EN
        , .stat_updates(a_upd), .stat_mispredicts(a_mis)
`endif
    );

    branch_predictor #(.ENTRIES(2), .COUNTER_BITS(1)) dut_b (
        .clk(clk), .rst(rst), .if__pc(if__pc), .if__stall(if__stall),
        .mb__update(mb__update), .mb__pc(mb__pc), .mb__taken(mb__taken),
        .mb__target(mb__target), .mb__mispredict(mb__mispredict),
        .if_id__predict_taken(b_taken), .if_id__predict_target(b_target)
`ifdef BRANCH_PREDICT_STATS_EN
        , .stat_updates(b_upd), .stat_mispredicts(b_mis)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one table per instance, entry index and tag from plain arithmetic.
    bit          m_valid [2][16];
    int unsigned m_tag   [2][16];
    int unsigned m_tgt   [2][16];
    int          m_ctr   [2][16];
    bit          exp_taken  [2];
    logic [31:0] exp_target [2];
    int unsigned m_upd = 0;
    int unsigned m_mis = 0;

    task automatic model_edge();
        for (int m = 0; m < 2; m++) begin
            int          eb = (m == 0) ? 4 : 1;
            int          cb = (m == 0) ? 2 : 1;
            int          n  = 1 << eb;
            int          cmax = (1 << cb) - 1;
            int          half = 1 << (cb - 1);
            int unsigned i;
            int unsigned t;
            if (rst) begin
                for (int k = 0; k < 16; k++) begin
                    m_valid[m][k] = 0;
                    m_ctr[m][k]   = 0;
                end
                exp_taken[m]  = 0;
                exp_target[m] = 32'd0;
            end else begin
                if (!if__stall) begin
                    i = (if__pc >> 2) % n;
                    t = if__pc >> (eb + 2);
                    exp_taken[m]  = m_valid[m][i] && (m_tag[m][i] == t) && (m_ctr[m][i] >= half);
                    exp_target[m] = exp_taken[m] ? m_tgt[m][i] : if__pc + 32'd4;
                end
                if (mb__update) begin
                    i = (mb__pc >> 2) % n;
                    t = mb__pc >> (eb + 2);
                    if (m_valid[m][i] && m_tag[m][i] == t) begin
                        if (mb__taken) begin
                            if (m_ctr[m][i] < cmax) m_ctr[m][i]++;
                            m_tgt[m][i] = mb__target;
                        end else if (m_ctr[m][i] > 0) begin
                            m_ctr[m][i]--;
                        end
                    end else if (mb__taken) begin
                        m_valid[m][i] = 1;
                        m_tag[m][i]   = t;
                        m_tgt[m][i]   = mb__target;
                        m_ctr[m][i]   = half;
                    end
                end
            end
        end
        if (rst) begin
            m_upd = 0;
            m_mis = 0;
        end else if (mb__update) begin
            m_upd++;
            if (mb__mispredict) m_mis++;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_update(input logic up, input logic [31:0] pc, input logic tk, input logic [31:0] tg);
        mb__update = up;
        mb__pc     = pc;
        mb__taken  = tk;
        mb__target = tg;
    endtask

    task automatic test_reset();
        rst = 1'b1; if__pc = 32'h100; if__stall = 1'b0; mb__mispredict = 1'b0;
        set_update(1'b1, 32'h100, 1'b1, 32'h40);
        cyc();
        n_tests++;
        if (a_taken !== 1'b0 || a_target !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_out: got taken=%0b target=%h, want taken=0 target=00000000", a_taken, a_target);
        end
        rst = 1'b0;
        set_update(1'b0, 32'h0, 1'b0, 32'h0);
        cyc();
        n_tests++;
        if (a_taken !== 1'b0 || a_target !== 32'h104) begin
            n_fail++;
            $display("FAIL cold_lookup: got taken=%0b target=%h, want taken=0 target=00000104", a_taken, a_target);
        end
        n_tests++;
        if (b_taken !== 1'b0 || b_target !== 32'h104) begin
            n_fail++;
            $display("FAIL cold_lookup_small: got taken=%0b target=%h, want taken=0 target=00000104", b_taken, b_target);
        end
    endtask

    task automatic test_allocate();
        if__pc = 32'h200;
        set_update(1'b1, 32'h100, 1'b1, 32'h40);
        cyc();
        set_update(1'b0, 32'h0, 1'b0, 32'h0);
        if__pc = 32'h100;
        cyc();
        n_tests++;
        if (a_taken !== 1'b1 || a_target !== 32'h40) begin
            n_fail++;
            $display("FAIL allocate: got taken=%0b target=%h, want taken=1 target=00000040", a_taken, a_target);
        end
        n_tests++;
        if (b_taken !== 1'b1 || b_target !== 32'h40) begin
            n_fail++;
            $display("FAIL allocate_small: got taken=%0b target=%h, want taken=1 target=00000040", b_taken, b_target);
        end
    endtask

    task automatic test_train();
        set_update(1'b1, 32'h100, 1'b0, 32'h0);
        cyc();
        cyc();
        set_update(1'b0, 32'h0, 1'b0, 32'h0);
        cyc();
        n_tests++;
        if (a_taken !== 1'b0 || a_target !== 32'h104) begin
            n_fail++;
            $display("FAIL train_down: got taken=%0b target=%h, want taken=0 target=00000104", a_taken, a_target);
        end
        set_update(1'b1, 32'h100, 1'b1, 32'h40);
        for (int k = 0; k < 5; k++) cyc();
        set_update(1'b1, 32'h100, 1'b0, 32'h0);
        cyc();
        set_update(1'b0, 32'h0, 1'b0, 32'h0);
        cyc();
        n_tests++;
        if (a_taken !== 1'b1 || a_target !== 32'h40) begin
            n_fail++;
            $display("FAIL saturate: got taken=%0b target=%h, want taken=1 target=00000040", a_taken, a_target);
        end
        n_tests++;
        if (b_taken !== 1'b0 || b_target !== 32'h104) begin
            n_fail++;
            $display("FAIL one_bit_nt: got taken=%0b target=%h, want taken=0 target=00000104", b_taken, b_target);
        end
        if__pc = 32'h104;
        cyc();
        n_tests++;
        if (b_taken !== 1'b0 || b_target !== 32'h108) begin
            n_fail++;
            $display("FAIL small_other_index: got taken=%0b target=%h, want taken=0 target=00000108", b_taken, b_target);
        end
    endtask

    task automatic test_alias();
        if__pc = 32'h140;
        cyc();
        n_tests++;
        if (a_taken !== 1'b0 || a_target !== 32'h144) begin
            n_fail++;
            $display("FAIL alias_miss: got taken=%0b target=%h, want taken=0 target=00000144", a_taken, a_target);
        end
        set_update(1'b1, 32'h140, 1'b1, 32'h80);
        cyc();
        set_update(1'b0, 32'h0, 1'b0, 32'h0);
        if__pc = 32'h100;
        cyc();
        n_tests++;
        if (a_taken !== 1'b0 || a_target !== 32'h104) begin
            n_fail++;
            $display("FAIL alias_evict: got taken=%0b target=%h, want taken=0 target=00000104", a_taken, a_target);
        end
        if__pc = 32'h140;
        cyc();
        n_tests++;
        if (a_taken !== 1'b1 || a_target !== 32'h80) begin
            n_fail++;
            $display("FAIL alias_new: got taken=%0b target=%h, want taken=1 target=00000080", a_taken, a_target);
        end
    endtask

    task automatic test_stall();
        logic [31:0] pcs [3];
        pcs[0] = 32'h100; pcs[1] = 32'h108; pcs[2] = 32'h10C;
        if__stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if__pc = pcs[k];
            if (k == 0) set_update(1'b1, 32'h104, 1'b1, 32'h300);
            else        set_update(1'b0, 32'h0, 1'b0, 32'h0);
            cyc();
            n_tests++;
            if (a_taken !== 1'b1 || a_target !== 32'h80) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got taken=%0b target=%h, want taken=1 target=00000080", k, a_taken, a_target);
            end
        end
        if__stall = 1'b0;
        if__pc = 32'h104;
        cyc();
        n_tests++;
        if (a_taken !== 1'b1 || a_target !== 32'h300) begin
            n_fail++;
            $display("FAIL stall_update: got taken=%0b target=%h, want taken=1 target=00000300", a_taken, a_target);
        end
    endtask

    task automatic test_collision();
        if__pc = 32'h100;
        set_update(1'b1, 32'h100, 1'b1, 32'h40);
        cyc();
        n_tests++;
        if (a_taken !== 1'b0 || a_target !== 32'h104) begin
            n_fail++;
            $display("FAIL rbw_old: got taken=%0b target=%h, want taken=0 target=00000104", a_taken, a_target);
        end
        set_update(1'b0, 32'h0, 1'b0, 32'h0);
        cyc();
        n_tests++;
        if (a_taken !== 1'b1 || a_target !== 32'h40) begin
            n_fail++;
            $display("FAIL rbw_new: got taken=%0b target=%h, want taken=1 target=00000040", a_taken, a_target);
        end
    endtask

`ifdef BRANCH_PREDICT_STATS_EN
    task automatic test_stats();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            set_update(1'b1, 32'h200 + 32'(k * 4), k[0], 32'h500);
            mb__mispredict = (k < 3);
            cyc();
        end
        set_update(1'b0, 32'h0, 1'b0, 32'h0);
        mb__mispredict = 1'b0;
        cyc();
        n_tests++;
        if (a_upd !== 32'd10 || a_mis !== 32'd3) begin
            n_fail++;
            $display("FAIL stats: got updates=%0d mispredicts=%0d, want updates=10 mispredicts=3", a_upd, a_mis);
        end
    endtask
`endif

    task automatic test_random();
        logic [31:0] bases [3];
        bases[0] = 32'h100; bases[1] = 32'h1100; bases[2] = 32'hFFFF_FFC0;
        for (int c = 0; c < 2000; c++) begin
            rst       = ($urandom_range(0, 99) == 0);
            if__stall = ($urandom_range(0, 4) == 0);
            if__pc    = bases[$urandom_range(0, 2)] + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
            set_update($urandom_range(0, 1) == 1,
                       bases[$urandom_range(0, 2)] + 32'($urandom_range(0, 15) * 4),
                       $urandom_range(0, 2) != 0, $urandom & 32'hFFFF_FFFC);
            mb__mispredict = $urandom_range(0, 1) == 1;
            cyc();
            n_tests++;
            if (a_taken !== exp_taken[0] || a_target !== exp_target[0] ||
                b_taken !== exp_taken[1] || b_target !== exp_target[1]) begin
                n_fail++;
                $display("FAIL random[%0d]: got a=%0b/%h b=%0b/%h, want a=%0b/%h b=%0b/%h", c,
                         a_taken, a_target, b_taken, b_target,
                         exp_taken[0], exp_target[0], exp_taken[1], exp_target[1]);
            end
`ifdef BRANCH_PREDICT_STATS_EN
            n_tests++;
            if (a_upd !== m_upd || a_mis !== m_mis || b_upd !== m_upd || b_mis !== m_mis) begin
                n_fail++;
                $display("FAIL random_stats[%0d]: got %0d/%0d, want %0d/%0d", c, a_upd, a_mis, m_upd, m_mis);
            end
`endif
        end
        rst = 1'b0;
        set_update(1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        rst = 1'b1; if__pc = 32'h0; if__stall = 1'b0; mb__mispredict = 1'b0;
        set_update(1'b0, 32'h0, 1'b0, 32'h0);
        test_reset();
        test_allocate();
        test_train();
        test_alias();
        test_stall();
        test_collision();
`ifdef BRANCH_PREDICT_STATS_EN
        test_stats();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
